// File: rtl/event_update_monitor_pkg.sv
// Shared definitions for the update/evaluate event monitor.
// Record layout, default sizes and a saturating-increment helper.
package event_update_monitor_pkg;

  localparam int TS_W_DEF  = 8;
  localparam int CNT_W_DEF = 16;
  localparam int DEPTH_DEF = 4;
  localparam int REC_W     = TS_W_DEF + 4;

  localparam int D_BIT  = 0;
  localparam int C_BIT  = 1;
  localparam int B_BIT  = 2;
  localparam int A_BIT  = 3;
  localparam int TS_LSB = 4;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input int          w
  );
    logic [31:0] max;
    max = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= max) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/event_update_monitor_if.sv
// Valid/ready record stream from the monitor to its reader.
// The master drives valid/data, the slave drives ready.
interface event_update_monitor_if
  import event_update_monitor_pkg::*;
#(
  parameter int W = REC_W
);

  logic         evt_valid;
  logic         evt_ready;
  logic [W-1:0] evt_data;

  modport master (
    output evt_valid,
    output evt_data,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_data,
    output evt_ready
  );

endinterface

// File: rtl/event_update_monitor_evt_fifo.sv
// First-word-fall-through FIFO over registered storage.
// Wrap-bit pointers; full/empty are registered from next pointers.
module evt_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic         full_q, full_d;
  logic         empty_q, empty_d;
  logic         pop_ok;
  logic         push_ok;

  // A pop frees a slot, so a push is taken when full if popping too.
  always_comb begin
    pop_ok  = pop_i & ~empty_q;
    push_ok = push_i & (~full_q | pop_ok);
    wr_d    = wr_q + (AW+1)'(push_ok);
    rd_d    = rd_q + (AW+1)'(pop_ok);
    empty_d = (wr_d == rd_d);
    full_d  = (wr_d[AW] != rd_d[AW]) &&
              (wr_d[AW-1:0] == rd_d[AW-1:0]);
  end

  // Pointer and flag state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Record storage; contents are masked on the output while empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_q[AW-1:0]] <= data_i;
    end
  end

  assign data_o  = empty_q ? '0 : mem_q[rd_q[AW-1:0]];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/event_update_monitor.sv
// Samples a/b, detects changes, evaluates c/d and queues
// timestamped records; counts events and dropped records.
module event_update_monitor
  import event_update_monitor_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int TS_W  = TS_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   a,
  input  logic                   b,
  event_update_monitor_if.master evt,
  output logic [CNT_W-1:0]       evt_count,
  output logic [CNT_W-1:0]       drop_count,
  output logic                   fifo_full,
  output logic                   fifo_empty
);

  localparam int RW = TS_W + 4;

  logic            a_s_q, b_s_q;
  logic            a_p_q, b_p_q;
  logic            s_vld_q;
  logic            primed_q;
  logic [TS_W-1:0] ts_q, ts_d;
  logic [CNT_W-1:0] evt_q, evt_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic            upd;
  logic            c, d;
  logic            pop;
  logic            drop;
  logic [RW-1:0]   rec;
  logic [RW-1:0]   head;

  // Sample inputs and keep previous samples; primed lags one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_s_q    <= 1'b0;
      b_s_q    <= 1'b0;
      a_p_q    <= 1'b0;
      b_p_q    <= 1'b0;
      s_vld_q  <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      a_s_q    <= a;
      b_s_q    <= b;
      a_p_q    <= a_s_q;
      b_p_q    <= b_s_q;
      s_vld_q  <= 1'b1;
      primed_q <= s_vld_q;
    end
  end

  // Detect, evaluate and build the record for the current cycle.
  always_comb begin
    upd = primed_q & ((a_s_q != a_p_q) | (b_s_q != b_p_q));
    c   = a_s_q & b_s_q;
    d   = a_s_q | (b_s_q ^ c);
    rec = '0;
    rec[D_BIT] = d;
    rec[C_BIT] = c;
    rec[B_BIT] = b_s_q;
    rec[A_BIT] = a_s_q;
    rec[TS_LSB +: TS_W] = ts_q;
  end

  // Next-state for timestamp and saturating counters.
  always_comb begin
    pop    = evt.evt_valid & evt.evt_ready;
    drop   = upd & fifo_full & ~pop;
    ts_d   = ts_q + TS_W'(1);
    evt_d  = evt_q;
    drop_d = drop_q;
    if (upd) begin
      evt_d = CNT_W'(sat_inc(32'(evt_q), CNT_W));
    end
    if (drop) begin
      drop_d = CNT_W'(sat_inc(32'(drop_q), CNT_W));
    end
  end

  // Timestamp and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q   <= '0;
      evt_q  <= '0;
      drop_q <= '0;
    end else begin
      ts_q   <= ts_d;
      evt_q  <= evt_d;
      drop_q <= drop_d;
    end
  end

  evt_fifo #(
    .DEPTH (DEPTH),
    .W     (RW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (upd),
    .data_i  (rec),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign evt.evt_valid = ~fifo_empty;
  assign evt.evt_data  = head;
  assign evt_count     = evt_q;
  assign drop_count    = drop_q;

endmodule

// File: tb/tb_event_update_monitor.sv
// Directed bench for event_update_monitor.
// Vector table plus hand-written full/drop/reset sequences.
module tb_event_update_monitor;

  logic        clk;
  logic        rst_n;
  logic        a, b;
  logic [15:0] evt_count;
  logic [15:0] drop_count;
  logic        fifo_full;
  logic        fifo_empty;

  event_update_monitor_if #(.W(12)) evt_bus ();

  event_update_monitor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a),
    .b          (b),
    .evt        (evt_bus),
    .evt_count  (evt_count),
    .drop_count (drop_count),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty)
  );

  typedef struct packed {
    logic a;
    logic b;
    logic c;
    logic d;
  } vec_t;

  vec_t        vecs [9];
  int          n_pass;
  int          n_tot;
  logic [7:0]  cyc;
  logic [7:0]  ts_e;
  logic [11:0] q [$];
  logic [11:0] rec_e;
  int          exp_evt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 8'd0;
    else        cyc <= cyc + 8'd1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else
      n_pass++;
  endtask

  function automatic logic [11:0] mk(input logic [7:0] t,
                                     input logic aa,
                                     input logic bb);
    logic cc, dd;
    cc = aa & bb;
    dd = aa | (bb ^ cc);
    return {t, aa, bb, cc, dd};
  endfunction

  task automatic one_event(input logic na, input logic nb,
                           input bit keep);
    @(posedge clk);
    #1 a = na; b = nb;
    @(posedge clk);
    #1;
    exp_evt++;
    if (keep) q.push_back(mk(cyc, na, nb));
  endtask

  initial begin
    n_pass  = 0;
    n_tot   = 0;
    exp_evt = 0;
    //             a     b     c     d
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    a = 1'b1;
    b = 1'b1;
    evt_bus.evt_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(evt_bus.evt_valid), 32'd0);
    chk("rst_data", 32'(evt_bus.evt_data), 32'd0);
    chk("rst_empty", 32'(fifo_empty), 32'd1);
    chk("rst_full", 32'(fifo_full), 32'd0);
    chk("rst_evt", 32'(evt_count), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("prime_evt", 32'(evt_count), 32'd0);
    chk("prime_valid", 32'(evt_bus.evt_valid), 32'd0);

    evt_bus.evt_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1 a = vecs[i].a; b = vecs[i].b;
      @(posedge clk);
      #1 ts_e = cyc;
      @(negedge clk);
      chk("vec_early", 32'(evt_bus.evt_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
      exp_evt++;
      chk("vec_valid", 32'(evt_bus.evt_valid), 32'd1);
      chk("vec_data", 32'(evt_bus.evt_data),
          32'({ts_e, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d}));
      chk("vec_evt", 32'(evt_count), 32'(exp_evt));
      @(posedge clk);
      @(negedge clk);
      chk("vec_popped", 32'(evt_bus.evt_valid), 32'd0);
    end

    evt_bus.evt_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      one_event(~a, b, i < 4);
    end
    @(posedge clk);
    @(negedge clk);
    chk("full_flag", 32'(fifo_full), 32'd1);
    chk("full_drop", 32'(drop_count), 32'd2);
    chk("full_evt", 32'(evt_count), 32'(exp_evt));
    chk("full_head", 32'(evt_bus.evt_data), 32'(q[0]));

    @(posedge clk);
    #1 a = ~a;
    @(posedge clk);
    #1 evt_bus.evt_ready = 1'b1;
    rec_e = mk(cyc, a, b);
    exp_evt++;
    @(negedge clk);
    chk("pp_head", 32'(evt_bus.evt_data), 32'(q[0]));
    @(posedge clk);
    #1 evt_bus.evt_ready = 1'b0;
    void'(q.pop_front());
    q.push_back(rec_e);
    @(negedge clk);
    chk("pp_full", 32'(fifo_full), 32'd1);
    chk("pp_drop", 32'(drop_count), 32'd2);
    chk("pp_evt", 32'(evt_count), 32'(exp_evt));

    evt_bus.evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("rd_valid", 32'(evt_bus.evt_valid), 32'd1);
      chk("rd_data", 32'(evt_bus.evt_data), 32'(q.pop_front()));
      @(posedge clk);
      @(negedge clk);
    end
    chk("rd_empty", 32'(fifo_empty), 32'd1);
    chk("rd_valid0", 32'(evt_bus.evt_valid), 32'd0);

    evt_bus.evt_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      one_event(a, ~b, 1'b0);
    end
    @(posedge clk);
    @(negedge clk);
    chk("mr_valid", 32'(evt_bus.evt_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_async_valid", 32'(evt_bus.evt_valid), 32'd0);
    chk("mr_async_empty", 32'(fifo_empty), 32'd1);
    chk("mr_async_evt", 32'(evt_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mr_evt", 32'(evt_count), 32'd0);
    chk("mr_drop", 32'(drop_count), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 a = ~a;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("mr_rec_valid", 32'(evt_bus.evt_valid), 32'd1);
    chk("mr_rec_ts", 32'(evt_bus.evt_data), 32'(mk(8'd3, a, b)));
    chk("mr_rec_evt", 32'(evt_count), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
